// File: rtl/dma_priority_arbiter.sv
// ---------------------------------------------------------------------------
// dma_priority_arbiter
//
// Purpose: four-channel DMA request arbiter. It qualifies per-channel requests
// (polarity and mask), asks the CPU for the bus with HRQ, and on hold
// acknowledge grants exactly one channel. The grant is frozen until the
// timing control signals the end of the service or the CPU revokes the bus.
//
// Optional feature: define DMA_ROTATING_PRIORITY_EN to build the rotating
// priority pointer. When it is defined, rotatePriority=1 selects rotating
// priority. Without it, rotatePriority is ignored and channel 0 is always
// highest.
//
// Ports:
//   CLK               rising-edge clock for all state
//   RESET_N           synchronous active-low reset
//   DREQ[3:0]         raw per-channel requests from the peripherals
//   HLDA              hold acknowledge from the CPU
//   maskReg[3:0]      1 = channel ignored
//   controllerDisable 1 = no new request sequence is started
//   rotatePriority    1 = rotating priority (only with the macro defined)
//   dreqSenseLow      1 = DREQ is active-low
//   transferDone      one-cycle end-of-service pulse
//   HRQ               hold request to the CPU
//   DACK[3:0]         one-hot acknowledge of the granted channel
//   activeChannel     encoded index of the granted channel
//   channelValid      1 while DACK is asserted
//
// state    | meaning
// ---------+---------------------------------------------------------------
// IDLE     | no bus request; waits for a qualified request while enabled
// REQUEST  | HRQ asserted; waits for HLDA, gives up if requests vanish
// GRANTED  | DACK asserted for the latched winner; grant is frozen
// RELEASE  | service finished; HRQ dropped, waits for HLDA to fall
// ---------------------------------------------------------------------------
module dma_priority_arbiter #(
    parameter int CHANNELS = 4
) (
    input  logic                        CLK,
    input  logic                        RESET_N,
    input  logic [CHANNELS-1:0]         DREQ,
    input  logic                        HLDA,
    input  logic [CHANNELS-1:0]         maskReg,
    input  logic                        controllerDisable,
    input  logic                        rotatePriority,
    input  logic                        dreqSenseLow,
    input  logic                        transferDone,
    output logic                        HRQ,
    output logic [CHANNELS-1:0]         DACK,
    output logic [$clog2(CHANNELS)-1:0] activeChannel,
    output logic                        channelValid
);

    localparam int CW = $clog2(CHANNELS);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_REQUEST  = 2'd1,
        ST_GRANTED  = 2'd2,
        ST_RELEASE  = 2'd3
    } state_t;

    state_t                state_q;
    state_t                state_d;
    logic [CW-1:0]         chan_q;
    logic [CW-1:0]         chan_d;

    logic [CHANNELS-1:0]   req;
    logic [CW-1:0]         ptr_eff;
    logic                  win_found;
    logic [CW-1:0]         win_idx;
    logic [CW-1:0]         cand;
    logic                  granted;

    // Qualified requests: polarity-corrected, then masked.
    always_comb begin
        req = (DREQ ^ {CHANNELS{dreqSenseLow}}) & ~maskReg;
    end

`ifdef DMA_ROTATING_PRIORITY_EN
    logic [CW-1:0] ptr_q;
    logic [CW-1:0] ptr_d;

    // The pointer only moves on a completed service. A revoked grant that
    // also carries transferDone still counts as completed.
    always_comb begin
        ptr_d = ptr_q;
        if ((state_q == ST_GRANTED) && transferDone && rotatePriority) begin
            ptr_d = chan_q + CW'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr_eff = rotatePriority ? ptr_q : '0;
`else
    logic unused_rotate;
    assign unused_rotate = rotatePriority;
    assign ptr_eff       = '0;
`endif

    // Search upward (mod CHANNELS) from the highest-priority position; a
    // zero pointer gives the fixed order 0..3.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            cand = ptr_eff + CW'(k);
            if (!win_found && req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        chan_d  = chan_q;
        case (state_q)
            ST_IDLE: begin
                if (!controllerDisable && (|req)) begin
                    state_d = ST_REQUEST;
                end
            end
            ST_REQUEST: begin
                if (!(|req)) begin
                    state_d = ST_IDLE;
                end else if (HLDA) begin
                    state_d = ST_GRANTED;
                    chan_d  = win_idx;
                end
            end
            ST_GRANTED: begin
                // Revocation wins over completion; the pointer logic above
                // still sees transferDone in that cycle.
                if (!HLDA) begin
                    state_d = ST_IDLE;
                end else if (transferDone) begin
                    state_d = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                if (!HLDA) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            state_q <= ST_IDLE;
            chan_q  <= '0;
        end else begin
            state_q <= state_d;
            chan_q  <= chan_d;
        end
    end

    // Outputs decode only registered state, so they are glitch-free towards
    // the datapath and frozen for the whole grant.
    always_comb begin
        granted       = (state_q == ST_GRANTED);
        HRQ           = (state_q == ST_REQUEST) || granted;
        DACK          = '0;
        if (granted) begin
            DACK[chan_q] = 1'b1;
        end
        activeChannel = granted ? chan_q : '0;
        channelValid  = granted;
    end

endmodule

// File: tb/tb_dma_priority_arbiter.sv
module tb_dma_priority_arbiter;

`ifdef DMA_ROTATING_PRIORITY_EN
    localparam bit ROT = 1'b1;
`else
    localparam bit ROT = 1'b0;
`endif

    logic       CLK = 1'b0;
    logic       RESET_N;
    logic [3:0] DREQ;
    logic       HLDA;
    logic [3:0] maskReg;
    logic       controllerDisable;
    logic       rotatePriority;
    logic       dreqSenseLow;
    logic       transferDone;
    logic       HRQ;
    logic [3:0] DACK;
    logic [1:0] activeChannel;
    logic       channelValid;

    int errors = 0;
    int checks = 0;

    dma_priority_arbiter #(.CHANNELS(4)) dut (
        .CLK               (CLK),
        .RESET_N           (RESET_N),
        .DREQ              (DREQ),
        .HLDA              (HLDA),
        .maskReg           (maskReg),
        .controllerDisable (controllerDisable),
        .rotatePriority    (rotatePriority),
        .dreqSenseLow      (dreqSenseLow),
        .transferDone      (transferDone),
        .HRQ               (HRQ),
        .DACK              (DACK),
        .activeChannel     (activeChannel),
        .channelValid      (channelValid)
    );

    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic chk_out(input string tag, input logic hrq_e, input logic [3:0] dack_e,
                           input logic [1:0] ac_e, input logic cv_e);
        chk({tag, ".HRQ"}, {7'd0, HRQ}, {7'd0, hrq_e});
        chk({tag, ".DACK"}, {4'd0, DACK}, {4'd0, dack_e});
        chk({tag, ".activeChannel"}, {6'd0, activeChannel}, {6'd0, ac_e});
        chk({tag, ".channelValid"}, {7'd0, channelValid}, {7'd0, cv_e});
    endtask

    task automatic wait_hrq(input string tag);
        int cyc = 0;
        while (HRQ !== 1'b1 && cyc < 8) begin
            step();
            cyc++;
        end
        chk(tag, {7'd0, HRQ}, 8'd1);
    endtask

    initial begin
        logic [1:0] exp_ch;

        RESET_N = 1'b0; DREQ = 4'b0000; HLDA = 1'b0; maskReg = 4'b0000;
        controllerDisable = 1'b0; rotatePriority = 1'b0; dreqSenseLow = 1'b0;
        transferDone = 1'b0;
        step(); step();
        chk_out("reset", 1'b0, 4'b0000, 2'd0, 1'b0);

        // Basic grant: DREQ=0110, HLDA two cycles after HRQ.
        RESET_N = 1'b1; DREQ = 4'b0110;
        step();
        chk_out("req_hrq", 1'b1, 4'b0000, 2'd0, 1'b0);
        step();
        chk_out("req_wait", 1'b1, 4'b0000, 2'd0, 1'b0);
        HLDA = 1'b1;
        step();
        chk_out("grant_ch1", 1'b1, 4'b0010, 2'd1, 1'b1);
        DREQ = 4'b0001; maskReg = 4'b0010;
        step();
        chk_out("grant_frozen", 1'b1, 4'b0010, 2'd1, 1'b1);
        transferDone = 1'b1;
        step();
        chk_out("release", 1'b0, 4'b0000, 2'd0, 1'b0);
        transferDone = 1'b0;
        step();
        chk_out("release_hold", 1'b0, 4'b0000, 2'd0, 1'b0);
        HLDA = 1'b0; DREQ = 4'b0000; maskReg = 4'b0000;
        step();

        // Masked request never raises HRQ.
        DREQ = 4'b0001; maskReg = 4'b0001;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("masked_no_hrq", {7'd0, HRQ}, 8'd0);
        end

        // Active-low sense: DREQ=1110 means only channel 0 requests.
        maskReg = 4'b0000; dreqSenseLow = 1'b1; DREQ = 4'b1110;
        step();
        chk("senselow_hrq", {7'd0, HRQ}, 8'd1);
        HLDA = 1'b1;
        step();
        chk_out("senselow_grant", 1'b1, 4'b0001, 2'd0, 1'b1);
        transferDone = 1'b1; HLDA = 1'b0;
        step();
        chk_out("senselow_revoke_done", 1'b0, 4'b0000, 2'd0, 1'b0);
        transferDone = 1'b0; dreqSenseLow = 1'b0; DREQ = 4'b0000;
        step();

        // Disable blocks new requests but not an in-progress grant.
        controllerDisable = 1'b1; DREQ = 4'b0001;
        step(); step(); step();
        chk("disable_no_hrq", {7'd0, HRQ}, 8'd0);
        controllerDisable = 1'b0;
        step();
        chk("enable_hrq", {7'd0, HRQ}, 8'd1);
        controllerDisable = 1'b1; HLDA = 1'b1;
        step();
        chk_out("disable_grant", 1'b1, 4'b0001, 2'd0, 1'b1);
        transferDone = 1'b1;
        step();
        chk_out("disable_release", 1'b0, 4'b0000, 2'd0, 1'b0);
        transferDone = 1'b0; HLDA = 1'b0; controllerDisable = 1'b0; DREQ = 4'b0000;
        step();

        // Request withdrawn before HLDA.
        DREQ = 4'b0100;
        step();
        chk("withdraw_hrq_up", {7'd0, HRQ}, 8'd1);
        DREQ = 4'b0000;
        step();
        chk_out("withdraw_drop", 1'b0, 4'b0000, 2'd0, 1'b0);
        step();
        chk_out("withdraw_idle", 1'b0, 4'b0000, 2'd0, 1'b0);

        // Rotating priority with all channels requesting.
        rotatePriority = 1'b1; DREQ = 4'b1111;
        for (int n = 0; n < 5; n++) begin
            wait_hrq("rot_hrq");
            HLDA = 1'b1;
            step();
            exp_ch = ROT ? 2'(n % 4) : 2'd0;
            chk("rot_channel", {6'd0, activeChannel}, {6'd0, exp_ch});
            chk("rot_dack", {4'd0, DACK}, {4'd0, 4'b0001 << exp_ch});
            transferDone = 1'b1;
            step();
            transferDone = 1'b0; HLDA = 1'b0;
            step();
        end

        // Reset in the middle of a channel-3 grant.
        DREQ = 4'b1000;
        wait_hrq("rst_hrq");
        HLDA = 1'b1;
        step();
        chk_out("rst_pre_grant", 1'b1, 4'b1000, 2'd3, 1'b1);
        RESET_N = 1'b0; HLDA = 1'b0; DREQ = 4'b0100;
        step();
        chk_out("rst_mid_grant", 1'b0, 4'b0000, 2'd0, 1'b0);
        RESET_N = 1'b1;

        // Grant on channel 2 revoked without transferDone.
        wait_hrq("revoke_hrq");
        HLDA = 1'b1;
        step();
        chk_out("revoke_pre", 1'b1, 4'b0100, 2'd2, 1'b1);
        HLDA = 1'b0; DREQ = 4'b1111;
        step();
        chk_out("revoke_drop", 1'b0, 4'b0000, 2'd0, 1'b0);
        wait_hrq("revoke_rearb_hrq");
        HLDA = 1'b1;
        step();
        chk_out("ptr_after_reset_revoke", 1'b1, 4'b0001, 2'd0, 1'b1);

        // Revoke and transferDone together still advance the pointer.
        HLDA = 1'b0; transferDone = 1'b1;
        step();
        chk_out("revoke_done_drop", 1'b0, 4'b0000, 2'd0, 1'b0);
        transferDone = 1'b0;
        wait_hrq("revoke_done_hrq");
        HLDA = 1'b1;
        step();
        exp_ch = ROT ? 2'd1 : 2'd0;
        chk("revoke_done_ptr", {6'd0, activeChannel}, {6'd0, exp_ch});
        transferDone = 1'b1;
        step();
        transferDone = 1'b0; HLDA = 1'b0; DREQ = 4'b0000;
        step();
        chk_out("final_idle", 1'b0, 4'b0000, 2'd0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/dma_priority_arbiter.md
DMA_PRIORITY_ARBITER -- requirements
Module: dma_priority_arbiter

Interface
REQ-001 The block SHALL take one parameter: CHANNELS, default 4, number of DMA request channels; only 4 is supported.
REQ-002 The block SHALL use one clock, CLK; reset is RESET_N, synchronous and active-low.
REQ-003 Port: CLK  input  1  rising-edge clock for all state.
REQ-004 Port: RESET_N  input  1  synchronous active-low reset.
REQ-005 Port: DREQ  input  4  per-channel DMA request from peripherals.
REQ-006 Port: HLDA  input  1  hold acknowledge from CPU.
REQ-007 Port: maskReg  input  4  per-channel mask; 1 = channel ignored.
REQ-008 Port: controllerDisable  input  1  command bit 2; 1 = no new requests accepted.
REQ-009 Port: rotatePriority  input  1  command bit 4; 1 = rotating priority.
REQ-010 Port: dreqSenseLow  input  1  command bit 6; 1 = DREQ active-low.
REQ-011 Port: transferDone  input  1  one-cycle pulse from timing control marking end of the granted service.
REQ-012 Port: HRQ  output  1  hold request to CPU.
REQ-013 Port: DACK  output  4  one-hot active-high acknowledge, consumed by the datapath.
REQ-014 Port: activeChannel  output  2  encoded index of the granted channel.
REQ-015 Port: channelValid  output  1  1 while DACK is asserted.

Function
REQ-016 Effective request SHALL be req[i] = (DREQ[i] XOR dreqSenseLow) AND NOT maskReg[i], evaluated every cycle.
REQ-017 The FSM SHALL have states IDLE, REQUEST, GRANTED, RELEASE.
REQ-018 IDLE: if controllerDisable=0 and any req, next state REQUEST; HRQ=1 from the following cycle.
REQ-019 REQUEST: HRQ=1; if no req, go to IDLE and drop HRQ; else if HLDA=1, go to GRANTED and latch the winner.
REQ-020 The winner SHALL be chosen from req in the cycle HLDA is first seen high in REQUEST; DACK[winner]=1 and channelValid=1 from the next cycle (latency 1 after HLDA).
REQ-021 GRANTED: DACK, activeChannel and HRQ SHALL hold constant; DREQ changes and mask changes SHALL NOT alter the grant.
REQ-022 GRANTED + transferDone=1: go to RELEASE; DACK=0, channelValid=0, HRQ=0 from the next cycle.
REQ-023 GRANTED + HLDA=0 (bus revoked): go to IDLE; DACK=0, HRQ=0 from the next cycle. If transferDone=1 in the same cycle, the priority update of REQ-026 still SHALL occur.
REQ-024 RELEASE: stay until HLDA=0, then go to IDLE; no request re-arbitration before IDLE.
REQ-025 Fixed priority: channel 0 highest, channel 3 lowest.
REQ-026 Rotating priority: on transferDone for channel n, the highest-priority pointer SHALL become (n+1) mod 4, wrapping 3->0; priority order follows ascending modulo-4 from the pointer.
REQ-027 The pointer SHALL update only on transferDone; a revoked grant without transferDone SHALL leave it unchanged.
REQ-028 controllerDisable=1 SHALL block IDLE->REQUEST only; an in-progress grant SHALL complete normally.
REQ-029 DACK SHALL never have more than one bit set; channelValid SHALL equal |DACK.

Reset
REQ-030 RESET_N=0 at a clock edge SHALL force state IDLE, HRQ=0, DACK=0, activeChannel=0, channelValid=0, priority pointer=0, from any state including GRANTED.

Configuration
REQ-031 Macro DMA_ROTATING_PRIORITY_EN: when defined, rotatePriority selects rotating priority per REQ-026; when undefined, the pointer logic SHALL be omitted, rotatePriority SHALL be ignored, and fixed priority of REQ-025 SHALL always apply.

Verification
REQ-032 DREQ=4'b0110, mask=0, HLDA raised 2 cycles after HRQ -> DACK=4'b0010, activeChannel=1 one cycle after HLDA.
REQ-033 Rotating (macro defined, rotatePriority=1), DREQ=4'b1111 held, four transferDone/HLDA cycles -> grant order 0,1,2,3, then 0 again.
REQ-034 DREQ=4'b0001, mask=4'b0001 -> HRQ stays 0 indefinitely; dreqSenseLow=1 with DREQ=4'b1110 -> channel 0 granted.
REQ-035 In GRANTED on channel 2, HLDA dropped without transferDone -> DACK=0, HRQ=0 next cycle; next arbitration with DREQ=4'b1111 still grants channel 0 (pointer unchanged).
REQ-036 RESET_N=0 for one cycle while DACK=4'b1000 -> all outputs 0 next cycle, state IDLE, pointer 0.
REQ-037 DREQ asserted then withdrawn before HLDA -> HRQ deasserts one cycle after withdrawal, DACK never asserted.
